// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter for four requesters. The granted index is presented as a 2-bit select
// code {a,b} for an external 2-to-4 decoder. Grants are held for at most HOLD_MAX cycles.
module rr_sel_arbiter #(
  parameter int unsigned HOLD_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       a,
  output logic       b,
  output logic       gnt_valid
);

  localparam logic [7:0] HoldLast = 8'(HOLD_MAX - 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] sel_q;
  logic [7:0] hold_cnt_q;
  logic       gnt_valid_q;

  logic [1:0] pick;
  logic       pick_vld;
  logic [1:0] idx;
  logic       release_now;

  // Walk the search order backwards so the lowest offset from ptr wins.
  always_comb begin
    pick     = 2'b00;
    pick_vld = 1'b0;
    idx      = 2'b00;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + 2'(i);
      if (req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  // All release causes fold into one condition, so ptr advances at most once per release.
  always_comb begin
    release_now = done | ~req[sel_q] | (hold_cnt_q == HoldLast);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 2'b00;
      sel_q       <= 2'b00;
      hold_cnt_q  <= 8'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_vld) begin
            sel_q       <= pick;
            hold_cnt_q  <= 8'd0;
            gnt_valid_q <= 1'b1;
            state_q     <= StGrant;
          end else begin
            gnt_valid_q <= 1'b0;
          end
        end
        StGrant: begin
          if (release_now) begin
            ptr_q       <= sel_q + 2'd1;
            gnt_valid_q <= 1'b0;
            state_q     <= StIdle;
          end else if (hold_cnt_q != 8'hFF) begin
            hold_cnt_q <= hold_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q     <= StIdle;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign a         = sel_q[1];
  assign b         = sel_q[0];
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Bench for rr_sel_arbiter: directed vector table, hand sequences and a randomized run, with
// two instances (HOLD_MAX=15 and HOLD_MAX=1) checked against a behavioural grant model.
module tb_rr_sel_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic       a15, b15, gv15;
  logic       a1, b1, gv1;

  int checks_total  = 0;
  int checks_passed = 0;

  rr_sel_arbiter #(.HOLD_MAX(15)) dut15 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .a         (a15),
    .b         (b15),
    .gnt_valid (gv15)
  );

  rr_sel_arbiter #(.HOLD_MAX(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .a         (a1),
    .b         (b1),
    .gnt_valid (gv1)
  );

  always #5 clk = ~clk;

  // Model: who holds the grant, for how many cycles so far, and where the next search starts.
  bit m_busy[2];
  int m_gidx[2];
  int m_ptr[2];
  int m_age[2];
  int m_last[2];

  task automatic model_step(input int k, input int hmax);
    if (!rst_n) begin
      m_busy[k] = 0;
      m_ptr[k]  = 0;
      m_age[k]  = 0;
      m_last[k] = 0;
    end else if (!m_busy[k]) begin
      for (int off = 0; off < 4; off++) begin
        int cand;
        cand = (m_ptr[k] + off) % 4;
        if (req[cand]) begin
          m_busy[k] = 1;
          m_gidx[k] = cand;
          m_last[k] = cand;
          m_age[k]  = 1;
          break;
        end
      end
    end else if (done || !req[m_gidx[k]] || m_age[k] >= hmax) begin
      m_busy[k] = 0;
      m_ptr[k]  = (m_gidx[k] + 1) % 4;
    end else begin
      m_age[k]++;
    end
  endtask

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s at %0t: {gnt_valid,a,b} got %b expected %b", name, $time, act, exp);
  endtask

  task automatic cycle(input logic [3:0] r, input logic d, input logic rn);
    req   = r;
    done  = d;
    rst_n = rn;
    @(posedge clk);
    model_step(0, 15);
    model_step(1, 1);
    #1;
    check("model_h15", {gv15, a15, b15}, {m_busy[0], 2'(m_last[0])});
    check("model_h1",  {gv1, a1, b1},    {m_busy[1], 2'(m_last[1])});
  endtask

  typedef struct {
    logic       rn;
    logic [3:0] r;
    logic       d;
    logic       exp_gv;
    logic [1:0] exp_sel;
  } vec_t;

  vec_t vecs[20];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_gidx[k] = 0; m_ptr[k] = 0; m_age[k] = 0; m_last[k] = 0;
    end
    req = 4'b0; done = 1'b0; rst_n = 1'b0;

    vecs[0]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'b00};  // reset
    vecs[1]  = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'b00};  // idle, nothing requested
    vecs[2]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'b10};  // 1-edge latency to grant 2
    vecs[3]  = '{1'b1, 4'b0100, 1'b0, 1'b1, 2'b10};
    vecs[4]  = '{1'b1, 4'b0101, 1'b0, 1'b1, 2'b10};  // other requester ignored
    vecs[5]  = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'b10};  // done releases, ptr -> 3
    vecs[6]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 2'b11};  // ptr 3 favours index 3
    vecs[7]  = '{1'b1, 4'b0001, 1'b0, 1'b0, 2'b11};  // req drop releases, ptr -> 0
    vecs[8]  = '{1'b1, 4'b1001, 1'b0, 1'b1, 2'b00};  // wrap-around to 0
    vecs[9]  = '{1'b1, 4'b0010, 1'b0, 1'b0, 2'b00};  // ptr -> 1
    vecs[10] = '{1'b1, 4'b0010, 1'b0, 1'b1, 2'b01};
    vecs[11] = '{1'b1, 4'b1100, 1'b1, 1'b0, 2'b01};  // coincident drop and done, ptr -> 2
    vecs[12] = '{1'b1, 4'b1001, 1'b0, 1'b1, 2'b11};  // 2 idle, so 3
    vecs[13] = '{1'b1, 4'b1000, 1'b1, 1'b0, 2'b11};  // ptr -> 0
    vecs[14] = '{1'b1, 4'b0000, 1'b0, 1'b0, 2'b11};  // code held while idle
    vecs[15] = '{1'b1, 4'b1000, 1'b0, 1'b1, 2'b11};
    vecs[16] = '{1'b0, 4'b1000, 1'b1, 1'b0, 2'b00};  // reset mid-grant with done
    vecs[17] = '{1'b1, 4'b1111, 1'b0, 1'b1, 2'b00};  // index 0 first after reset
    vecs[18] = '{1'b1, 4'b1111, 1'b0, 1'b1, 2'b00};
    vecs[19] = '{1'b0, 4'b0000, 1'b0, 1'b0, 2'b00};

    cycle(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(vecs[i].r, vecs[i].d, vecs[i].rn);
      check($sformatf("vec%0d", i), {gv15, a15, b15}, {vecs[i].exp_gv, vecs[i].exp_sel});
    end

    // Full load: each grant lasts HOLD_MAX cycles followed by one idle cycle.
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 15; c++) begin
        cycle(4'b1111, 1'b0, 1'b1);
        check($sformatf("hold_g%0d_c%0d", g, c), {gv15, a15, b15}, {1'b1, 2'(g % 4)});
      end
      cycle(4'b1111, 1'b0, 1'b1);
      check($sformatf("gap_g%0d", g), {gv15, a15, b15}, {1'b0, 2'(g % 4)});
    end

    cycle(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      logic       d;
      logic       rn;
      r  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : req;
      d  = ($urandom_range(0, 7) == 0);
      rn = ($urandom_range(0, 99) != 0);
      cycle(r, d, rn);
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
